// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: decodes a multiplexed active-low 7-seg bus back into a qualified hex value
module seg7_scan_capture #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 3,
  parameter int TIMEOUT    = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [6:0]                     seg_n,
  input  logic [DIGITS-1:0]              an_n,
  output logic [4*DIGITS-1:0]            value,
  output logic                           value_valid,
  output logic                           digit_err,
  output logic [(DIGITS>1 ? $clog2(DIGITS) : 1)-1:0] err_digit,
  output logic                           timeout
);
  localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] IDLE = 2'd0, TRACK = 2'd1, LOCKED = 2'd2;
  localparam logic [6:0] ENC [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [6:0]          seg_m, seg_s, cur_pat;
  logic [DIGITS-1:0]   an_m, an_s, sel, captured, cap_nx;
  logic [1:0]          state;
  logic [DW-1:0]       cur_dig, dig;
  logic [CW-1:0]       cnt, ncnt;
  logic [TW-1:0]       tcnt;
  logic [4*DIGITS-1:0] shadow;
  logic [3:0]          nib;
  logic                ok, q, same, hold, acc, frame;
  assign sel   = ~an_s;
  assign q     = (sel != '0) && ((sel & (sel - DIGITS'(1))) == '0);
  assign same  = (dig == cur_dig) && (seg_s == cur_pat);
  assign ncnt  = (state == TRACK && same) ? cnt + CW'(1) : CW'(1);
  assign hold  = (state == LOCKED) && same;
  assign acc   = q && !hold && (ncnt >= CW'(STABLE_CNT));
  assign frame = &captured;
  assign timeout = tcnt == TW'(TIMEOUT);
  // index of the single enabled digit
  always_comb begin
    dig = '0;
    for (int i = 0; i < DIGITS; i++) if (sel[i]) dig = DW'(i);
  end
  // inverse of the encoder table; anything not in it is undecodable
  always_comb begin
    ok  = 1'b0;
    nib = '0;
    for (int i = 0; i < 16; i++) if (seg_s == ENC[i]) begin ok = 1'b1; nib = 4'(i); end
  end
  // completion clears the mask first so a same-cycle accept lands in the new frame
  always_comb begin
    cap_nx = frame ? '0 : captured;
    if (acc) cap_nx[dig] = ok;
  end
  // two-flop synchronizers for the asynchronous display bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_m <= '0;
      seg_s <= '0;
      an_m  <= '0;
      an_s  <= '0;
    end else begin
      seg_m <= seg_n;
      seg_s <= seg_m;
      an_m  <= an_n;
      an_s  <= an_m;
    end
  end
  // stability tracker: IDLE -> TRACK until STABLE_CNT matching samples -> LOCKED
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_dig <= '0;
      cur_pat <= '0;
      cnt     <= '0;
    end else if (!q) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (!hold) begin
      state   <= acc ? LOCKED : TRACK;
      cur_dig <= dig;
      cur_pat <= seg_s;
      cnt     <= ncnt;
    end
  end
  // shadow capture, frame publication and error reporting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= '0;
      captured    <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      digit_err   <= 1'b0;
      err_digit   <= '0;
    end else begin
      captured    <= cap_nx;
      value_valid <= frame;
      digit_err   <= acc && !ok;
      if (frame) value <= shadow;
      if (acc && ok) shadow[4*dig +: 4] <= nib;
      if (acc && !ok) err_digit <= dig;
    end
  end
  // frame watchdog, saturating at TIMEOUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt <= '0;
    else tcnt <= frame ? '0 : (timeout ? tcnt : tcnt + TW'(1));
  end
endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: directed checks of the seven-segment scan capture
module tb_seg7_scan_capture;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_n = 7'h7f;
  logic [3:0]  an_n = 4'hf;
  logic [15:0] value;
  logic        value_valid, digit_err, timeout;
  logic [1:0]  err_digit;
  int checks = 0, errors = 0;
  int vv_cnt = 0, err_cnt = 0, err_at = -1;

  seg7_scan_capture dut (
    .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .an_n(an_n),
    .value(value), .value_valid(value_valid), .digit_err(digit_err),
    .err_digit(err_digit), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n) begin
    if (value_valid) vv_cnt++;
    if (digit_err) begin err_cnt++; err_at = int'(err_digit); end
  end

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'b1000000; 4'h1: enc = 7'b1111001; 4'h2: enc = 7'b0100100; 4'h3: enc = 7'b0110000;
      4'h4: enc = 7'b0011001; 4'h5: enc = 7'b0010010; 4'h6: enc = 7'b0000010; 4'h7: enc = 7'b1111000;
      4'h8: enc = 7'b0000000; 4'h9: enc = 7'b0010000; 4'hA: enc = 7'b0001000; 4'hB: enc = 7'b0000011;
      4'hC: enc = 7'b1000110; 4'hD: enc = 7'b0100001; 4'hE: enc = 7'b0000110; default: enc = 7'b0001110;
    endcase
  endfunction

  task automatic raw(input logic [6:0] s, input logic [3:0] a, input int cyc);
    seg_n = s;
    an_n  = a;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic show(input int d, input logic [3:0] n, input int cyc);
    logic [3:0] one;
    one = 4'b0001 << d;
    raw(enc(n), ~one, cyc);
  endtask

  task automatic scan(input logic [15:0] v);
    for (int d = 0; d < 4; d++) show(d, v[4*d +: 4], 8);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) raw(7'($urandom), 4'($urandom), 1);
    @(negedge clk);
    checks++; if (value !== 16'h0) begin errors++; $display("FAIL reset_value got %h exp 0000", value); end
    checks++; if ({value_valid, digit_err, timeout} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {value_valid, digit_err, timeout}); end
    checks++; if (err_digit !== 2'd0) begin errors++; $display("FAIL reset_err_digit got %0d exp 0", err_digit); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    raw(7'h7f, 4'hf, 20);
    for (int d = 0; d < 3; d++) show(d, 4'h5, 8);
    checks++; if (vv_cnt !== 0) begin errors++; $display("FAIL reset_no_frame got %0d exp 0", vv_cnt); end
  endtask

  task automatic test_clean;
    int v0;
    v0 = vv_cnt;
    repeat (3) scan(16'h1A3F);
    checks++; if (vv_cnt - v0 !== 3) begin errors++; $display("FAIL clean_pulses got %0d exp 3", vv_cnt - v0); end
    checks++; if (value !== 16'h1A3F) begin errors++; $display("FAIL clean_value got %h exp 1a3f", value); end
    v0 = vv_cnt;
    scan(16'h1A7F);
    checks++; if (vv_cnt - v0 !== 1) begin errors++; $display("FAIL change_pulses got %0d exp 1", vv_cnt - v0); end
    checks++; if (value !== 16'h1A7F) begin errors++; $display("FAIL change_value got %h exp 1a7f", value); end
  endtask

  task automatic test_glitch;
    int v0;
    v0 = vv_cnt;
    show(0, 4'hF, 8); show(1, 4'h7, 8); show(2, 4'hA, 2); show(3, 4'h1, 8);
    checks++; if (vv_cnt - v0 !== 0) begin errors++; $display("FAIL glitch_pulses got %0d exp 0", vv_cnt - v0); end
    v0 = vv_cnt;
    scan(16'h1A7F);
    checks++; if (vv_cnt - v0 !== 1) begin errors++; $display("FAIL glitch_recover got %0d exp 1", vv_cnt - v0); end
    checks++; if (value !== 16'h1A7F) begin errors++; $display("FAIL glitch_value got %h exp 1a7f", value); end
  endtask

  task automatic test_invalid;
    int v0, e0;
    v0 = vv_cnt;
    e0 = err_cnt;
    show(0, 4'hF, 8); show(1, 4'h7, 8); raw(7'h7f, 4'b1011, 8); show(3, 4'h1, 8);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL invalid_err_pulses got %0d exp 1", err_cnt - e0); end
    checks++; if (err_at !== 2) begin errors++; $display("FAIL invalid_err_digit got %0d exp 2", err_at); end
    checks++; if (vv_cnt - v0 !== 0) begin errors++; $display("FAIL invalid_pulses got %0d exp 0", vv_cnt - v0); end
    v0 = vv_cnt;
    scan(16'h1A7F);
    checks++; if (vv_cnt - v0 !== 1) begin errors++; $display("FAIL invalid_recover got %0d exp 1", vv_cnt - v0); end
  endtask

  task automatic test_ghost;
    int v0;
    v0 = vv_cnt;
    for (int d = 0; d < 4; d++) begin
      show(d, d == 0 ? 4'hF : d == 1 ? 4'h7 : d == 2 ? 4'hA : 4'h1, 8);
      raw(enc(4'h8), 4'b1100, 6);
      raw(enc(4'h8), 4'b1111, 6);
    end
    checks++; if (vv_cnt - v0 !== 1) begin errors++; $display("FAIL ghost_pulses got %0d exp 1", vv_cnt - v0); end
    checks++; if (value !== 16'h1A7F) begin errors++; $display("FAIL ghost_value got %h exp 1a7f", value); end
  endtask

  task automatic test_timeout;
    int v0;
    raw(7'h7f, 4'hf, 950);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_early got %b exp 0", timeout); end
    raw(7'h7f, 4'hf, 100);
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_set got %b exp 1", timeout); end
    v0 = vv_cnt;
    scan(16'h1A7F);
    checks++; if (vv_cnt - v0 !== 1) begin errors++; $display("FAIL timeout_frame got %0d exp 1", vv_cnt - v0); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b exp 0", timeout); end
  endtask

  task automatic test_reset_mid_frame;
    int v0;
    show(0, 4'hF, 8); show(1, 4'h7, 8);
    rst_n = 1'b0;
    raw(7'h7f, 4'hf, 3);
    checks++; if (value !== 16'h0) begin errors++; $display("FAIL midreset_value got %h exp 0000", value); end
    rst_n = 1'b1;
    v0 = vv_cnt;
    show(2, 4'hC, 8); show(3, 4'h5, 8);
    checks++; if (vv_cnt - v0 !== 0) begin errors++; $display("FAIL midreset_partial got %0d exp 0", vv_cnt - v0); end
    show(0, 4'hE, 8); show(1, 4'h9, 8);
    checks++; if (vv_cnt - v0 !== 1) begin errors++; $display("FAIL midreset_frame got %0d exp 1", vv_cnt - v0); end
    checks++; if (value !== 16'h5C9E) begin errors++; $display("FAIL midreset_value2 got %h exp 5c9e", value); end
  endtask

  initial begin
    test_reset;
    test_clean;
    test_glitch;
    test_invalid;
    test_ghost;
    test_timeout;
    test_reset_mid_frame;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
